// File: rtl/panel_scan_reader.sv
// panel_scan_reader: HUB75 16x16 1/8-scan driver that fetches RGB565 pixels from RAM
// and shows 4 binary-weighted bit planes per row.
`default_nettype none

module panel_scan_reader #(
    parameter int BASE_ON_CYCLES = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    output logic [7:0]  o_r_addr,
    output logic        o_r_enable,
    input  logic [15:0] i_r_data,
    output logic [2:0]  o_rgb1,
    output logic [2:0]  o_rgb2,
    output logic [2:0]  o_row,
    output logic        o_clk,
    output logic        o_lat,
    output logic        o_oe_n,
    output logic        o_frame_done
);

    localparam int CNT_W = $clog2(BASE_ON_CYCLES * 8 + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_TOP  = 3'd1,
        RD_BOT  = 3'd2,
        CLK_LO  = 3'd3,
        CLK_HI  = 3'd4,
        BLANK   = 3'd5,
        LATCH   = 3'd6,
        DISPLAY = 3'd7
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        col;
    logic [2:0]        row;
    logic [1:0]        plane;
    logic [CNT_W-1:0]  on_cnt;
    logic [CNT_W-1:0]  on_len;
    logic              on_last;
    logic [15:0]       top_pix;
    logic [7:0]        addr_hold;
    logic [2:0]        rgb1_hold;
    logic [2:0]        rgb2_hold;
    logic [2:0]        row_hold;
    logic              frame_done;

    function automatic logic [2:0] plane_bits(input logic [15:0] pix, input logic [1:0] p);
        plane_bits = {pix[4'd12 + {2'b00, p}], pix[4'd7 + {2'b00, p}], pix[4'd1 + {2'b00, p}]};
    endfunction

    assign on_len  = CNT_W'(BASE_ON_CYCLES) << plane;
    assign on_last = (on_cnt == on_len - CNT_W'(1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_enable) state_next = RD_TOP;
            RD_TOP:  state_next = RD_BOT;
            RD_BOT:  state_next = CLK_LO;
            CLK_LO:  state_next = CLK_HI;
            CLK_HI:  state_next = (col == 4'd15) ? BLANK : RD_TOP;
            BLANK:   state_next = LATCH;
            LATCH:   state_next = DISPLAY;
            DISPLAY: if (on_last) state_next = i_enable ? RD_TOP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            col        <= '0;
            row        <= '0;
            plane      <= '0;
            on_cnt     <= '0;
            top_pix    <= '0;
            addr_hold  <= '0;
            rgb1_hold  <= '0;
            rgb2_hold  <= '0;
            row_hold   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == DISPLAY) && on_last && (plane == 2'd3) && (row == 3'd7);
            case (state)
                IDLE: begin
                    col    <= '0;
                    row    <= '0;
                    plane  <= '0;
                    on_cnt <= '0;
                end
                RD_TOP: addr_hold <= {1'b0, row, col};
                RD_BOT: begin
                    addr_hold <= {1'b1, row, col};
                    top_pix   <= i_r_data;
                end
                // i_r_data carries the bottom pixel during this state
                CLK_LO: begin
                    rgb1_hold <= plane_bits(top_pix, plane);
                    rgb2_hold <= plane_bits(i_r_data, plane);
                end
                CLK_HI: col <= col + 4'd1;
                BLANK:  row_hold <= row;
                LATCH:  on_cnt <= '0;
                DISPLAY: begin
                    if (on_last) begin
                        on_cnt <= '0;
                        plane  <= plane + 2'd1;
                        if (plane == 2'd3) row <= row + 3'd1;
                    end else begin
                        on_cnt <= on_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Address and colour are presented combinationally in their own state so the
    // data is settled before the HUB75 clock rises; registers hold them afterwards.
    always_comb begin
        o_r_addr = addr_hold;
        if (state == RD_TOP) o_r_addr = {1'b0, row, col};
        if (state == RD_BOT) o_r_addr = {1'b1, row, col};
    end

    assign o_rgb1       = (state == CLK_LO) ? plane_bits(top_pix, plane)  : rgb1_hold;
    assign o_rgb2       = (state == CLK_LO) ? plane_bits(i_r_data, plane) : rgb2_hold;
    assign o_r_enable   = (state == RD_TOP) || (state == RD_BOT);
    assign o_row        = row_hold;
    assign o_clk        = (state == CLK_HI);
    assign o_lat        = (state == LATCH);
    assign o_oe_n       = (state != DISPLAY);
    assign o_frame_done = frame_done;

endmodule

`default_nettype wire

// File: tb/tb_panel_scan_reader.sv
// tb_panel_scan_reader: directed self-checking bench for panel_scan_reader.
`default_nettype none

module tb_panel_scan_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  r_addr;
    logic        r_enable;
    logic [15:0] r_data = '0;
    logic [2:0]  rgb1, rgb2, row;
    logic        pclk, lat, oe_n, frame_done;

    int checks = 0;
    int failures = 0;
    int viol = 0;
    int mode = 0;

    int m_cycles, m_clks, m_lats, m_oe_low, m_rgb_bad, m_lat_row;
    logic [7:0] addrs[$];

    always #5 clk = ~clk;

    panel_scan_reader #(.BASE_ON_CYCLES(8)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_enable     (enable),
        .o_r_addr     (r_addr),
        .o_r_enable   (r_enable),
        .i_r_data     (r_data),
        .o_rgb1       (rgb1),
        .o_rgb2       (rgb2),
        .o_row        (row),
        .o_clk        (pclk),
        .o_lat        (lat),
        .o_oe_n       (oe_n),
        .o_frame_done (frame_done)
    );

    function automatic logic [15:0] ram_word(input logic [7:0] a);
        case (mode)
            0:       ram_word = 16'hFFFF;
            1:       ram_word = {8'h00, a};
            default: ram_word = a[7] ? 16'h0000 : 16'h1082;
        endcase
    endfunction

    always @(posedge clk) if (r_enable) r_data <= ram_word(r_addr);

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_start();
        int ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (r_enable && !r_addr[7] && r_addr[3:0] == 4'd0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("start_seen", ok, 1);
    endtask

    // Samples one plane period, starting on RD_TOP col 0 and stopping on the
    // first sample after OE returns high.
    task automatic measure(input logic [2:0] e1, input logic [2:0] e2, input bit chk_rgb, input bit drop);
        bit seen_low = 1'b0;
        m_cycles = 0; m_clks = 0; m_lats = 0; m_oe_low = 0; m_rgb_bad = 0; m_lat_row = -1;
        addrs.delete();
        for (int i = 0; i < 400; i++) begin
            if (oe_n && seen_low) break;
            if (pclk) begin
                m_clks++;
                if (chk_rgb && (rgb1 !== e1 || rgb2 !== e2)) m_rgb_bad++;
            end
            if (lat) begin
                m_lats++;
                m_lat_row = int'(row);
            end
            if (!oe_n) begin
                m_oe_low++;
                if (!seen_low && drop) enable = 1'b0;
                seen_low = 1'b1;
            end
            if (r_enable) addrs.push_back(r_addr);
            if ((lat && pclk) || (!oe_n && (lat || pclk || r_enable))) viol++;
            m_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int new_mode);
        @(negedge clk);
        reset_n = 1'b0;
        mode = new_mode;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int sum;
        int steps;
        int bad;
        int n;
        int found;
        logic [7:0] exp_a;

        repeat (3) @(negedge clk);
        chk("rst_oe_n", int'(oe_n), 1);
        chk("rst_r_enable", int'(r_enable), 0);
        chk("rst_r_addr", int'(r_addr), 0);
        chk("rst_rgb1", int'(rgb1), 0);
        chk("rst_rgb2", int'(rgb2), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_clk", int'(pclk), 0);
        chk("rst_lat", int'(lat), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_read", int'(r_enable), 0);

        // All-white RAM: four planes of row 0, then the rest of the frame
        enable = 1'b1;
        wait_start();
        sum = 0;
        for (int p = 0; p < 4; p++) begin
            measure(3'b111, 3'b111, 1'b1, 1'b0);
            sum += m_cycles;
            chk($sformatf("A_p%0d_period", p), m_cycles, 66 + (8 << p));
            chk($sformatf("A_p%0d_clks", p), m_clks, 16);
            chk($sformatf("A_p%0d_lats", p), m_lats, 1);
            chk($sformatf("A_p%0d_oe_low", p), m_oe_low, 8 << p);
            chk($sformatf("A_p%0d_rgb_bad", p), m_rgb_bad, 0);
        end
        steps = 0;
        while (!frame_done && steps < 4000) begin
            @(negedge clk);
            steps++;
        end
        chk("A_frame_cycles", sum + steps, 3072);
        @(negedge clk);
        chk("A_frame_done_single", int'(frame_done), 0);

        // Address-pattern RAM: read order for row 0
        do_reset(1);
        wait_start();
        measure(3'b000, 3'b000, 1'b0, 1'b0);
        chk("B_addr_count", addrs.size(), 32);
        bad = 0;
        for (int i = 0; i < 32 && i < addrs.size(); i++) begin
            exp_a = (i % 2 == 1) ? (8'h80 | 8'(i / 2)) : 8'(i / 2);
            if (addrs[i] !== exp_a) bad++;
        end
        chk("B_addr_seq_bad", bad, 0);
        chk("B_first_addr", int'(addrs.size() > 0 ? addrs[0] : 8'hFF), 0);
        chk("B_lat_row", m_lat_row, 0);

        // Single-pixel-bit RAM, then drop enable in row 2 plane 1
        do_reset(2);
        wait_start();
        for (int p = 0; p < 4; p++) begin
            measure((p == 0) ? 3'b111 : 3'b000, 3'b000, 1'b1, 1'b0);
            chk($sformatf("C_p%0d_rgb_bad", p), m_rgb_bad, 0);
        end
        for (int k = 0; k < 5; k++) begin
            measure((k % 4 == 0) ? 3'b111 : 3'b000, 3'b000, 1'b1, 1'b0);
        end
        measure(3'b000, 3'b000, 1'b1, 1'b1);
        chk("D_oe_low", m_oe_low, 16);
        chk("D_lat_row", m_lat_row, 2);
        chk("D_period", m_cycles, 82);
        chk("D_rgb_bad", m_rgb_bad, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (r_enable || !oe_n) bad++;
            @(negedge clk);
        end
        chk("D_idle_bad", bad, 0);

        // Asynchronous reset during CLK_HI of column 7
        mode = 0;
        enable = 1'b1;
        wait_start();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (pclk) begin
                n++;
                if (n == 8) break;
            end
            @(negedge clk);
        end
        chk("E_reached_col7", n, 8);
        reset_n = 1'b0;
        #1;
        chk("E_oe_n", int'(oe_n), 1);
        chk("E_clk", int'(pclk), 0);
        chk("E_r_enable", int'(r_enable), 0);
        chk("E_rgb1", int'(rgb1), 0);
        chk("E_r_addr", int'(r_addr), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (r_enable) begin
                found = 1;
                break;
            end
        end
        chk("E_read_found", found, 1);
        chk("E_first_addr", int'(r_addr), 0);

        chk("invariant_viol", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/panel_scan_reader.md
PANEL_SCAN_READER -- requirements
Module: panel_scan_reader

Interface
REQ-001 SHALL have parameter BASE_ON_CYCLES, default 8, OE-active cycles for bit plane 0.
REQ-002 SHALL have port i_clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_reset_n  in  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port i_enable  in  1  scan enable.
REQ-005 SHALL have port o_r_addr  out  8  pixel RAM read address {half, row[2:0], col[3:0]}.
REQ-006 SHALL have port o_r_enable  out  1  pixel RAM read enable.
REQ-007 SHALL have port i_r_data  in  16  pixel RAM read data, RGB565, valid 1 cycle after address.
REQ-008 SHALL have ports o_rgb1 / o_rgb2  out  3 each  HUB75 top/bottom data, bit2=R, bit1=G, bit0=B.
REQ-009 SHALL have ports o_row  out  3, o_clk  out  1, o_lat  out  1, o_oe_n  out  1 (HUB75 A-C, CLK, LAT, OE active-low).
REQ-010 SHALL have port o_frame_done  out  1  one-cycle pulse at end of each full frame.

Function
REQ-011 SHALL scan a 16x16 panel at 1/8 scan: 8 rows x 16 columns x 2 halves = 256 pixels, 4 bit planes (0..3).
REQ-012 SHALL take plane p from pixel bits R=data[12+p], G=data[7+p], B=data[1+p].
REQ-013 SHALL implement states IDLE, RD_TOP, RD_BOT, CLK_LO, CLK_HI, BLANK, LATCH, DISPLAY.
REQ-014 IDLE: o_oe_n=1, o_r_enable=0; on i_enable=1 -> RD_TOP with col=0, row=0, plane=0.
REQ-015 RD_TOP: o_r_addr={1'b0,row,col}, o_r_enable=1 -> RD_BOT.
REQ-016 RD_BOT: o_r_addr={1'b1,row,col}, o_r_enable=1, register top pixel from i_r_data -> CLK_LO.
REQ-017 CLK_LO: register bottom pixel; drive o_rgb1/o_rgb2 from plane bits; o_clk=0 -> CLK_HI.
REQ-018 CLK_HI: o_clk=1, rgb held; col==15 -> BLANK, else col+1 -> RD_TOP.
REQ-019 BLANK: o_oe_n=1, o_row updated to current row -> LATCH.
REQ-020 LATCH: o_lat=1 exactly one cycle, o_oe_n=1 -> DISPLAY.
REQ-021 DISPLAY: o_oe_n=0 for exactly BASE_ON_CYCLES<<plane cycles, counter width sufficient for BASE_ON_CYCLES*8.
REQ-022 After DISPLAY: plane+1; plane 3->0 wraps and row+1; row 7->0 wraps and pulses o_frame_done for 1 cycle.
REQ-023 After DISPLAY: i_enable=0 -> IDLE (o_oe_n=1); else RD_TOP with col=0; i_enable ignored elsewhere.
REQ-024 o_r_enable SHALL be 0 in all states except RD_TOP/RD_BOT; o_r_addr holds last value otherwise.
REQ-025 Plane period SHALL be 66 + (BASE_ON_CYCLES<<plane) cycles from RD_TOP col 0 to next RD_TOP col 0.
REQ-026 o_oe_n SHALL be 1 in every state except DISPLAY; o_lat and o_clk never high together.

Reset
REQ-027 On i_reset_n=0, immediately: state IDLE, col/row/plane/counter 0, o_oe_n=1, all other outputs 0.
REQ-028 Reset asserted mid-operation SHALL abandon the scan; after release scanning restarts at row 0, plane 0.

Verification
REQ-029 RAM model all 16'hFFFF, BASE_ON_CYCLES=8, enable -> per plane 16 o_clk pulses with rgb1=rgb2=3'b111, one o_lat, OE low 8/16/32/64 cycles for planes 0..3.
REQ-030 RAM addr a holds {8'h00,a} -> o_r_addr sequence 0x00,0x80,0x01,0x81...0x0F,0x8F for row 0; o_row=0 at first LATCH.
REQ-031 Full frame with enable held -> o_frame_done single pulse after row 7 plane 3 DISPLAY; total 32 plane periods, 4*8*66+8*(8+16+32+64)=3072 cycles.
REQ-032 Drop i_enable during row 2 plane 1 DISPLAY -> plane completes, state IDLE, o_oe_n=1, no further RAM reads.
REQ-033 Assert i_reset_n=0 during CLK_HI of col 7 -> outputs reset asynchronously same cycle; after release and enable, first read address 0x00.
REQ-034 Pixel 16'h1082 (R bit12, G bit7, B bit1) top only -> rgb1=3'b111 in plane 0, 3'b000 in planes 1-3; rgb2=0 throughout.
